// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the shared data-memory port between the core
// LD/ST port (requester 0) and the network memory loader (requester 1).
module dmem_arbiter #(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32,
    parameter int timeout_p    = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                req_valid_i,
    input  logic [1:0]                req_wen_i,
    input  logic [1:0]                req_byte_i,
    input  logic [2*addr_width_p-1:0] req_addr_i,
    input  logic [2*data_width_p-1:0] req_wdata_i,
    output logic [1:0]                req_yumi_o,
    output logic [1:0]                resp_valid_o,
    output logic [data_width_p-1:0]   resp_data_o,
    input  logic [1:0]                resp_yumi_i,
    output logic                      mem_valid_o,
    output logic                      mem_wen_o,
    output logic                      mem_byte_o,
    output logic [addr_width_p-1:0]   mem_addr_o,
    output logic [data_width_p-1:0]   mem_wdata_o,
    input  logic                      mem_ready_i,
    input  logic                      mem_rvalid_i,
    input  logic [data_width_p-1:0]   mem_rdata_i,
    output logic                      busy_o,
    output logic                      owner_o,
    output logic                      error_o
);
    localparam int tw_lp = $clog2(timeout_p + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_q, last_d;
    logic                    wen_q, wen_d;
    logic                    byte_q, byte_d;
    logic [addr_width_p-1:0] addr_q, addr_d;
    logic [data_width_p-1:0] wdata_q, wdata_d;
    logic [data_width_p-1:0] rdata_q, rdata_d;
    logic [tw_lp-1:0]        timer_q, timer_d;
    logic                    err_q, err_d;
    logic                    grant;
    logic                    timer_hit;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        unique case (req_valid_i)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_q;
            default: grant = 1'b0;
        endcase
    end

    assign timer_hit = (timer_q + tw_lp'(1)) == tw_lp'(timeout_p);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        wen_d      = wen_q;
        byte_d     = byte_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        timer_d    = timer_q;
        err_d      = err_q;
        req_yumi_o = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    req_yumi_o[grant] = 1'b1;
                    owner_d = grant;
                    wen_d   = req_wen_i[grant];
                    byte_d  = req_byte_i[grant];
                    addr_d  = grant ? req_addr_i[addr_width_p +: addr_width_p]
                                    : req_addr_i[0 +: addr_width_p];
                    wdata_d = grant ? req_wdata_i[data_width_p +: data_width_p]
                                    : req_wdata_i[0 +: data_width_p];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ready_i) begin
                    timer_d = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A completion in the final cycle still beats the watchdog.
                if (mem_rvalid_i) begin
                    rdata_d = mem_rdata_i;
                    state_d = RESP;
                end else if (timer_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + tw_lp'(1);
                end
            end
            RESP: begin
                if (resp_yumi_i[owner_q]) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            wen_q   <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wen_q   <= wen_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    assign mem_valid_o  = (state_q == ISSUE);
    assign mem_wen_o    = wen_q;
    assign mem_byte_o   = byte_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign resp_valid_o = (state_q != RESP) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
    assign resp_data_o  = rdata_q;
    assign busy_o       = (state_q != IDLE);
    assign owner_o      = owner_q;
    assign error_o      = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: random traffic against a transaction-level
// model, then directed fairness, backpressure, watchdog and reset cases.
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    req_valid_i = '0;
    logic [1:0]    req_wen_i = '0;
    logic [1:0]    req_byte_i = '0;
    logic [2*AW-1:0] req_addr_i = '0;
    logic [2*DW-1:0] req_wdata_i = '0;
    logic [1:0]    req_yumi_o;
    logic [1:0]    resp_valid_o;
    logic [DW-1:0] resp_data_o;
    logic [1:0]    resp_yumi_i = '0;
    logic          mem_valid_o;
    logic          mem_wen_o;
    logic          mem_byte_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ready_i = 1'b0;
    logic          mem_rvalid_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          busy_o;
    logic          owner_o;
    logic          error_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] mmem [int];

    always #5 clk = ~clk;

    dmem_arbiter #(
        .addr_width_p(AW),
        .data_width_p(DW),
        .timeout_p   (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid_i),
        .req_wen_i   (req_wen_i),
        .req_byte_i  (req_byte_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_yumi_o  (req_yumi_o),
        .resp_valid_o(resp_valid_o),
        .resp_data_o (resp_data_o),
        .resp_yumi_i (resp_yumi_i),
        .mem_valid_o (mem_valid_o),
        .mem_wen_o   (mem_wen_o),
        .mem_byte_o  (mem_byte_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ready_i (mem_ready_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i),
        .busy_o      (busy_o),
        .owner_o     (owner_o),
        .error_o     (error_o)
    );

    task automatic chk(input string tag, input logic [95:0] got,
                       input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic quiet;
        req_valid_i  = '0;
        req_wen_i    = '0;
        req_byte_i   = '0;
        resp_yumi_i  = '0;
        mem_ready_i  = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    task automatic do_reset;
        quiet();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic set_req(input int k, input logic w, input logic b,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_wen_i[k]          = w;
        req_byte_i[k]         = b;
        req_addr_i[k*AW +: AW] = a;
        req_wdata_i[k*DW +: DW] = d;
    endtask

    task automatic drain;
        req_valid_i  = '0;
        mem_ready_i  = 1'b1;
        mem_rvalid_i = 1'b1;
        resp_yumi_i  = 2'b11;
        for (int i = 0; i < 20 && busy_o; i++) step();
        quiet();
        smp();
        chk("drain_idle", busy_o, 0);
    endtask

    // Complete read: grant, immediate accept, lat silent WAIT cycles, data.
    task automatic run_read(input string tag, input int k,
                            input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int lat);
        step();
        req_valid_i = 2'b01 << k;
        set_req(k, 1'b0, 1'b0, a, '0);
        smp();
        chk({tag, "_yumi"}, req_yumi_o, 2'b01 << k);
        step();
        req_valid_i = '0;
        mem_ready_i = 1'b1;
        for (int i = 0; i < lat; i++) begin
            step();
            mem_ready_i = 1'b0;
        end
        step();
        mem_ready_i  = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = d;
        step();
        mem_rvalid_i = 1'b0;
        resp_yumi_i  = 2'b01 << k;
        smp();
        chk({tag, "_resp"}, resp_valid_o, 2'b01 << k);
        chk({tag, "_data"}, resp_data_o, d);
        step();
        resp_yumi_i = '0;
        smp();
        chk({tag, "_done"}, busy_o, 0);
    endtask

    // Transaction model: phase 0 free, 1 granted, 2 at memory, 3 response held.
    task automatic rand_run(input int ncyc);
        int            phase = 0;
        int            own = 0;
        int            last = 1;
        int            lat = 0;
        bit            pend = 0;
        logic [1:0]    gflag = '0;
        logic [1:0]    eyumi;
        logic          t_wen = 0, t_byte = 0;
        logic [AW-1:0] t_addr = '0;
        logic [DW-1:0] t_wdata = '0, t_rdata = '0;
        for (int c = 0; c < ncyc; c++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                if (gflag[k]) req_valid_i[k] = 1'b0;
                else if (req_valid_i[k] && $urandom_range(15) == 0)
                    req_valid_i[k] = 1'b0;
                else if (!req_valid_i[k] && !(phase != 0 && own == k)
                         && $urandom_range(2) == 0) begin
                    req_valid_i[k] = 1'b1;
                    set_req(k, 1'($urandom_range(1)), 1'($urandom_range(1)),
                            AW'($urandom_range(31)), $urandom);
                end
            end
            mem_ready_i = 1'($urandom_range(1));
            resp_yumi_i = 2'($urandom_range(3));
            if (pend) begin
                if (lat == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = t_wen ? $urandom
                                 : (mmem.exists(int'(t_addr)) ? mmem[int'(t_addr)]
                                                               : ~t_addr);
                end else begin
                    mem_rvalid_i = 1'b0;
                    lat--;
                end
            end else begin
                mem_rvalid_i = ($urandom_range(7) == 0);
                mem_rdata_i  = $urandom;
            end
            smp();
            eyumi = 2'b00;
            if (phase == 0 && req_valid_i != 2'b00)
                eyumi = (req_valid_i == 2'b11) ? ((last == 1) ? 2'b01 : 2'b10)
                                               : req_valid_i;
            chk("r_yumi", req_yumi_o, eyumi);
            chk("r_busy", busy_o, phase != 0);
            chk("r_mvalid", mem_valid_o, phase == 1);
            if (phase == 1) begin
                chk("r_maddr", mem_addr_o, t_addr);
                chk("r_mctl", {mem_wen_o, mem_byte_o, mem_wdata_o},
                    {t_wen, t_byte, t_wdata});
            end
            chk("r_rvalid", resp_valid_o,
                (phase == 3) ? ((own == 1) ? 2'b10 : 2'b01) : 2'b00);
            if (phase == 3) chk("r_rdata", resp_data_o, t_rdata);
            chk("r_owner", owner_o, own);
            chk("r_error", error_o, 0);
            gflag = eyumi;
            if (phase == 0 && eyumi != 2'b00) begin
                own     = eyumi[1] ? 1 : 0;
                t_wen   = req_wen_i[own];
                t_byte  = req_byte_i[own];
                t_addr  = req_addr_i[own*AW +: AW];
                t_wdata = req_wdata_i[own*DW +: DW];
                phase   = 1;
            end else if (phase == 1 && mem_ready_i) begin
                phase = 2;
                pend  = 1;
                lat   = $urandom_range(4);
            end else if (phase == 2 && mem_rvalid_i) begin
                t_rdata = mem_rdata_i;
                if (t_wen) mmem[int'(t_addr)] = t_wdata;
                pend  = 0;
                phase = 3;
            end else if (phase == 3 && resp_yumi_i[own]) begin
                last  = own;
                phase = 0;
            end
        end
        quiet();
        drain();
    endtask

    initial begin
        int acc;
        int ng;
        int lastc;
        int prevg;
        quiet();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        smp();
        chk("rst_ctl", {req_yumi_o, resp_valid_o, mem_valid_o, mem_wen_o,
                        mem_byte_o, busy_o, owner_o, error_o}, 0);
        chk("rst_rdata", resp_data_o, 0);
        chk("rst_maddr", mem_addr_o, 0);
        chk("rst_mwdata", mem_wdata_o, 0);
        step();
        reset = 1'b0;

        rand_run(3000);

        // Single read.
        do_reset();
        step();
        req_valid_i = 2'b01;
        set_req(0, 1'b0, 1'b0, 32'h40, '0);
        smp();
        chk("rd_yumi", req_yumi_o, 2'b01);
        step();
        req_valid_i = '0;
        mem_ready_i = 1'b1;
        smp();
        chk("rd_mvalid", mem_valid_o, 1);
        chk("rd_mreq", {mem_wen_o, mem_addr_o}, {1'b0, 32'h40});
        chk("rd_owner", owner_o, 0);
        step();
        mem_ready_i = 1'b0;
        smp();
        chk("rd_wait", {mem_valid_o, busy_o}, 2'b01);
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1234_5678;
        step();
        mem_rvalid_i = 1'b0;
        smp();
        chk("rd_rvalid", resp_valid_o, 2'b01);
        chk("rd_rdata", resp_data_o, 32'h1234_5678);
        step();
        resp_yumi_i = 2'b01;
        smp();
        chk("rd_hold", resp_valid_o, 2'b01);
        step();
        resp_yumi_i = '0;
        smp();
        chk("rd_idle", {busy_o, resp_valid_o}, 0);

        // Both requesters valid continuously.
        do_reset();
        step();
        req_valid_i = 2'b11;
        set_req(0, 1'b0, 1'b0, 32'h100, '0);
        set_req(1, 1'b0, 1'b0, 32'h200, '0);
        mem_ready_i  = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBEEF;
        resp_yumi_i  = 2'b11;
        ng = 0;
        lastc = 0;
        prevg = -1;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            smp();
            if (prevg >= 0) begin
                chk("alt_owner", owner_o, prevg);
                prevg = -1;
            end
            if (req_yumi_o != 2'b00) begin
                chk("alt_grant", req_yumi_o, (ng % 2 == 0) ? 2'b01 : 2'b10);
                if (ng > 0) chk("alt_gap", c - lastc, 4);
                lastc = c;
                prevg = req_yumi_o[1] ? 1 : 0;
                ng++;
            end
            step();
        end
        chk("alt_count", ng, 4);
        drain();

        // Requester 1 byte store under memory backpressure.
        step();
        req_valid_i = 2'b10;
        set_req(1, 1'b1, 1'b1, 32'h7, 32'hA5);
        smp();
        chk("bp_yumi", req_yumi_o, 2'b10);
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            req_valid_i = '0;
            mem_ready_i = (i == 5);
            smp();
            chk("bp_mreq", {mem_valid_o, mem_wen_o, mem_byte_o, mem_addr_o,
                            mem_wdata_o}, {3'b111, 32'h7, 32'hA5});
            acc += int'(mem_valid_o & mem_ready_i);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            mem_ready_i = 1'b1;
            smp();
            acc += int'(mem_valid_o & mem_ready_i);
        end
        chk("bp_accept", acc, 1);
        chk("bp_owner", owner_o, 1);
        step();
        mem_ready_i  = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h55;
        step();
        mem_rvalid_i = 1'b0;
        smp();
        chk("bp_resp", resp_valid_o, 2'b10);
        chk("bp_rdata", resp_data_o, 32'h55);
        drain();

        // Response stall with requester 1 waiting.
        step();
        req_valid_i = 2'b01;
        set_req(0, 1'b0, 1'b0, 32'h80, '0);
        smp();
        chk("st_yumi0", req_yumi_o, 2'b01);
        step();
        req_valid_i = 2'b10;
        set_req(1, 1'b0, 1'b0, 32'h84, '0);
        mem_ready_i = 1'b1;
        step();
        mem_ready_i  = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFE_0001;
        step();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
        resp_yumi_i  = 2'b10;
        for (int i = 0; i < 10; i++) begin
            smp();
            chk("st_rvalid", resp_valid_o, 2'b01);
            chk("st_rdata", resp_data_o, 32'hCAFE_0001);
            chk("st_noyumi", req_yumi_o, 0);
            step();
        end
        resp_yumi_i = 2'b01;
        smp();
        chk("st_yumi_cyc", req_yumi_o, 0);
        step();
        resp_yumi_i = '0;
        smp();
        chk("st_grant1", req_yumi_o, 2'b10);
        drain();

        // Watchdog, stray completion, then a normal transaction.
        do_reset();
        step();
        req_valid_i = 2'b01;
        set_req(0, 1'b0, 1'b0, 32'hC0, '0);
        step();
        req_valid_i = '0;
        mem_ready_i = 1'b1;
        for (int i = 0; i < TO; i++) begin
            step();
            mem_ready_i = 1'b0;
            smp();
            chk("wd_pending", {error_o, resp_valid_o, busy_o}, 4'b0001);
        end
        step();
        smp();
        chk("wd_err", error_o, 1);
        chk("wd_resp", resp_valid_o, 2'b01);
        chk("wd_data", resp_data_o, 0);
        step();
        resp_yumi_i = 2'b01;
        step();
        resp_yumi_i  = '0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD;
        smp();
        chk("wd_stray", {busy_o, resp_valid_o}, 0);
        step();
        mem_rvalid_i = 1'b0;
        smp();
        chk("wd_stray2", {busy_o, resp_valid_o, error_o}, 4'b0001);
        run_read("wd_next", 1, 32'h44, 32'h0BAD_F00D, 1);
        chk("wd_sticky", error_o, 1);

        // Completion in the very cycle the watchdog would fire.
        do_reset();
        run_read("bd", 0, 32'h48, 32'h7777_0001, TO - 1);
        chk("bd_err", error_o, 0);

        // Asynchronous reset while waiting on memory.
        do_reset();
        step();
        req_valid_i = 2'b01;
        set_req(0, 1'b0, 1'b0, 32'h10, '0);
        step();
        req_valid_i = '0;
        mem_ready_i = 1'b1;
        step();
        mem_ready_i = 1'b0;
        smp();
        chk("ar_inwait", busy_o, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_drop", {busy_o, resp_valid_o, mem_valid_o}, 0);
        step();
        reset = 1'b0;
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h9999;
        smp();
        chk("ar_stray", {busy_o, resp_valid_o}, 0);
        step();
        mem_rvalid_i = 1'b0;
        req_valid_i  = 2'b11;
        set_req(0, 1'b0, 1'b0, 32'h20, '0);
        set_req(1, 1'b0, 1'b0, 32'h24, '0);
        smp();
        chk("ar_first", req_yumi_o, 2'b01);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
